// File: rtl/ps2_kbd_tx.sv
`timescale 1ns/1ps
// ============================================================================
// ps2_kbd_tx -- host-to-device PS/2 command transmitter.
//
// Sends one command byte to a PS/2 keyboard: inhibits the bus by holding CLK
// low, issues the start bit, shifts out 8 data bits LSB first plus odd parity
// and a stop bit on the device-generated clock, then samples the device ack.
// A watchdog aborts the frame if the device stops clocking.
//
// Ports
//   SYSTEM_CLOCK      in     system clock, rising edge; all state lives here
//   reset             in     asynchronous, active-high
//   write_kbtdr       in     one-cycle request to send kbtdr_in (idle only)
//   kbtdr_in[7:0]     in     command byte
//   kbtsr             out    1 = idle and ready to accept a write
//   tx_ack            out    one-cycle pulse when the device acks the frame
//   tx_error          out    sticky: timeout or missing ack on the last frame
//   PS2KEYBOARD_CLK   inout  open-drain PS/2 clock (driven 0 or released)
//   PS2KEYBOARD_DATA  inout  open-drain PS/2 data  (driven 0 or released)
// ============================================================================
module ps2_kbd_tx #(
    parameter int INHIBIT_CYCLES = 200,
    parameter int TIMEOUT_CYCLES = 30000
) (
    input  logic       SYSTEM_CLOCK,
    input  logic       reset,
    input  logic       write_kbtdr,
    input  logic [7:0] kbtdr_in,
    output logic       kbtsr,
    output logic       tx_ack,
    output logic       tx_error,
    inout  wire        PS2KEYBOARD_CLK,
    inout  wire        PS2KEYBOARD_DATA
);

    // One counter serves both the inhibit interval and the watchdog; it is
    // sized for the larger of the two so neither can wrap.
    localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                   : TIMEOUT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t           r_state,      w_state_nxt;
    logic [7:0]       r_data,       w_data_nxt;
    logic             r_parity,     w_parity_nxt;
    logic [3:0]       r_bit_cnt,    w_bit_cnt_nxt;
    logic [CNT_W-1:0] r_cnt,        w_cnt_nxt;
    logic             r_clk_low,    w_clk_low_nxt;
    logic             r_data_low,   w_data_low_nxt;
    logic             r_tx_ack,     w_tx_ack_nxt;
    logic             r_tx_error,   w_tx_error_nxt;

    // [0] = metastability stage, [1] = synchronized value
    logic [1:0]       r_clk_sync;
    logic [1:0]       r_data_sync;
    logic             r_clk_prev;

    logic             w_clk_s;
    logic             w_data_s;
    logic             w_fall;
    logic             w_watched;

    // ------------------------------------------------------------------
    // Pin synchronizers and falling-edge detect on the synchronized clock.
    // Reset to 1 so a released bus never looks like a falling edge.
    // ------------------------------------------------------------------
    // NOTE: clocked state is always assigned with <= so every flop samples the
    // pre-edge value of its neighbours; = here would collapse the 2-flop chain.
    always_ff @(posedge SYSTEM_CLOCK or posedge reset) begin
        if (reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0],  PS2KEYBOARD_CLK};
            r_data_sync <= {r_data_sync[0], PS2KEYBOARD_DATA};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    assign w_clk_s   = r_clk_sync[1];
    assign w_data_s  = r_data_sync[1];
    assign w_fall    = r_clk_prev & ~w_clk_s;
    assign w_watched = (r_state == SEND) || (r_state == ACK) || (r_state == WAIT_IDLE);

    // ------------------------------------------------------------------
    // Register process
    // ------------------------------------------------------------------
    always_ff @(posedge SYSTEM_CLOCK or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_data     <= 8'h00;
            r_parity   <= 1'b0;
            r_bit_cnt  <= 4'd0;
            r_cnt      <= '0;
            r_clk_low  <= 1'b0;
            r_data_low <= 1'b0;
            r_tx_ack   <= 1'b0;
            r_tx_error <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_data     <= w_data_nxt;
            r_parity   <= w_parity_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_cnt      <= w_cnt_nxt;
            r_clk_low  <= w_clk_low_nxt;
            r_data_low <= w_data_low_nxt;
            r_tx_ack   <= w_tx_ack_nxt;
            r_tx_error <= w_tx_error_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    // NOTE: every signal gets a default before the case; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_data_nxt     = r_data;
        w_parity_nxt   = r_parity;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_cnt_nxt      = r_cnt;
        w_clk_low_nxt  = r_clk_low;
        w_data_low_nxt = r_data_low;
        w_tx_ack_nxt   = 1'b0;
        w_tx_error_nxt = r_tx_error;

        case (r_state)
            IDLE: begin
                // Bus traffic from the device is ignored here on purpose.
                w_cnt_nxt      = '0;
                w_bit_cnt_nxt  = 4'd0;
                w_clk_low_nxt  = 1'b0;
                w_data_low_nxt = 1'b0;
                if (write_kbtdr) begin
                    w_data_nxt     = kbtdr_in;
                    w_parity_nxt   = ~^kbtdr_in;
                    w_tx_error_nxt = 1'b0;
                    w_clk_low_nxt  = 1'b1;
                    w_state_nxt    = INHIBIT;
                end
            end

            INHIBIT: begin
                if (r_cnt == INHIBIT_LAST) begin
                    // Start bit and CLK release happen on the same edge.
                    w_clk_low_nxt  = 1'b0;
                    w_data_low_nxt = 1'b1;
                    w_cnt_nxt      = '0;
                    w_bit_cnt_nxt  = 4'd0;
                    w_state_nxt    = SEND;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            SEND: begin
                if (w_fall) begin
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt < 4'd8) begin
                        w_data_low_nxt = ~r_data[r_bit_cnt[2:0]];
                    end else if (r_bit_cnt == 4'd8) begin
                        w_data_low_nxt = ~r_parity;
                    end else begin
                        w_data_low_nxt = 1'b0;   // stop bit: release
                        w_state_nxt    = ACK;
                    end
                end
            end

            ACK: begin
                if (w_fall) begin
                    if (!w_data_s) begin
                        w_tx_ack_nxt   = 1'b1;
                    end else begin
                        w_tx_error_nxt = 1'b1;
                    end
                    w_state_nxt = WAIT_IDLE;
                end
            end

            WAIT_IDLE: begin
                if (w_clk_s && w_data_s) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Watchdog: restarts on each device clock edge; expiry overrides
        // whatever the state logic above decided.
        if (w_watched) begin
            if (w_fall) begin
                w_cnt_nxt = '0;
            end else if (r_cnt == TIMEOUT_LAST) begin
                w_cnt_nxt      = '0;
                w_bit_cnt_nxt  = 4'd0;
                w_clk_low_nxt  = 1'b0;
                w_data_low_nxt = 1'b0;
                w_tx_ack_nxt   = 1'b0;
                w_tx_error_nxt = 1'b1;
                w_state_nxt    = IDLE;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    // Open-drain pins come straight from flops, so they cannot glitch.
    assign PS2KEYBOARD_CLK  = r_clk_low  ? 1'b0 : 1'bz;
    assign PS2KEYBOARD_DATA = r_data_low ? 1'b0 : 1'bz;

    assign kbtsr    = (r_state == IDLE);
    assign tx_ack   = r_tx_ack;
    assign tx_error = r_tx_error;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
`timescale 1ns/1ps
// ============================================================================
// tb_ps2_kbd_tx -- self-checking bench for ps2_kbd_tx.
//
// A behavioural PS/2 keyboard drives the open-drain bus (with pull-ups),
// generates the device clock, samples the host bits on rising clock edges and
// optionally acks. Expected bytes/parity/ack/error come from the byte sent and
// the chosen device behaviour.
// ============================================================================
module tb_ps2_kbd_tx;

    localparam int INHIBIT_CYCLES = 200;
    localparam int TIMEOUT_CYCLES = 30000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write_kbtdr = 1'b0;
    logic [7:0] kbtdr_in = 8'h00;
    logic       kbtsr;
    logic       tx_ack;
    logic       tx_error;

    wire        ps2_clk;
    wire        ps2_data;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;

    int         n_checks  = 0;
    int         n_errors  = 0;
    int         ack_count = 0;
    int         dev_edge  = 0;

    always #250 clk = ~clk;   // 2 MHz

    assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = dev_data_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_data);

    ps2_kbd_tx #(
        .INHIBIT_CYCLES(INHIBIT_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .SYSTEM_CLOCK    (clk),
        .reset           (rst),
        .write_kbtdr     (write_kbtdr),
        .kbtdr_in        (kbtdr_in),
        .kbtsr           (kbtsr),
        .tx_ack          (tx_ack),
        .tx_error        (tx_error),
        .PS2KEYBOARD_CLK (ps2_clk),
        .PS2KEYBOARD_DATA(ps2_data)
    );

    always @(negedge clk) begin
        if (tx_ack === 1'b1) ack_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_write(input logic [7:0] d);
        write_kbtdr = 1'b1;
        kbtdr_in    = d;
        @(negedge clk);
        write_kbtdr = 1'b0;
    endtask

    // Wait (bounded) for the bus clock line to reach a level.
    task automatic wait_clk_level(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (ps2_clk !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, ps2_clk, lvl);
    endtask

    // Keyboard side of one host-to-device frame.
    task automatic dev_frame(input int half, input bit do_ack, input string tag,
                             output logic [7:0] rx, output logic rx_par, output logic rx_stop);
        int   inh    = 0;
        bit   clk_ok = 1'b1;
        logic s;
        rx = 8'h00; rx_par = 1'bx; rx_stop = 1'bx;
        dev_edge = 0;
        wait_clk_level(1'b0, 1000, {tag, "_inhibit_seen"});
        while (ps2_clk === 1'b0 && inh < 1000) begin
            inh++;
            @(negedge clk);
        end
        check({tag, "_inhibit_len"}, inh, INHIBIT_CYCLES);
        check({tag, "_start_bit"}, ps2_data, 1'b0);
        cycles(half);
        for (int e = 1; e <= 10; e++) begin
            if (ps2_clk !== 1'b1) clk_ok = 1'b0;
            dev_clk_low = 1'b1;
            dev_edge    = e;
            cycles(half);
            s = ps2_data;             // device samples on its rising edge
            dev_clk_low = 1'b0;
            if (e <= 8)      rx[e-1] = s;
            else if (e == 9) rx_par  = s;
            else             rx_stop = s;
            cycles(half);
        end
        if (do_ack) dev_data_low = 1'b1;
        cycles(5);
        dev_clk_low = 1'b1;
        dev_edge    = 11;
        cycles(half);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        cycles(half);
        check({tag, "_clk_never_held"}, clk_ok, 1'b1);
    endtask

    // Device frame after the write has been issued, plus result checks
    // derived from the byte and the device's ack choice.
    task automatic finish_frame(input logic [7:0] d, input int half, input bit do_ack,
                                input string tag);
        logic [7:0] rx;
        logic       par, stop;
        logic       exp_par;
        int         a0 = ack_count;
        exp_par = (($countones(d) % 2) == 0);   // odd parity over data + parity
        dev_frame(half, do_ack, tag, rx, par, stop);
        cycles(10);
        check({tag, "_byte"},   rx, d);
        check({tag, "_parity"}, par, exp_par);
        check({tag, "_stop"},   stop, 1'b1);
        check({tag, "_acks"},   ack_count - a0, do_ack ? 1 : 0);
        check({tag, "_error"},  tx_error, !do_ack);
        check({tag, "_kbtsr"},  kbtsr, 1'b1);
    endtask

    task automatic run_frame(input logic [7:0] d, input int half, input bit do_ack,
                             input string tag);
        host_write(d);
        finish_frame(d, half, do_ack, tag);
    endtask

    // Device-to-host traffic on the shared pins while the host is idle.
    task automatic dev_send_rx(input logic [7:0] d, input int half);
        logic [10:0] bits;
        bits = {1'b1, ~^d, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            dev_data_low = ~bits[i];
            cycles(half / 2);
            dev_clk_low = 1'b1;
            cycles(half);
            dev_clk_low = 1'b0;
            cycles(half / 2);
        end
        dev_data_low = 1'b0;
        cycles(20);
    endtask

    initial begin
        #40_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int a0;

        // ---------------- reset state ----------------
        cycles(5);
        check("rst_kbtsr",    kbtsr,    1'b1);
        check("rst_tx_ack",   tx_ack,   1'b0);
        check("rst_tx_error", tx_error, 1'b0);
        check("rst_clk_pin",  ps2_clk,  1'b1);
        check("rst_data_pin", ps2_data, 1'b1);
        rst = 1'b0;
        cycles(5);

        // ---------------- nominal frame at 10 kHz ----------------
        run_frame(8'hED, 100, 1'b1, "nominal");

        // ---------------- parity corners ----------------
        run_frame(8'h00, 50, 1'b1, "par00");
        run_frame(8'hFF, 50, 1'b1, "parFF");
        run_frame(8'h01, 50, 1'b1, "par01");

        // ---------------- missing ack ----------------
        run_frame(8'hA5, 50, 1'b0, "noack");

        // ---------------- idle receive traffic changes nothing ----------------
        a0 = ack_count;
        dev_send_rx(8'h1C, 40);
        check("rx_idle_kbtsr", kbtsr,    1'b1);
        check("rx_idle_error", tx_error, 1'b1);
        check("rx_idle_acks",  ack_count - a0, 0);

        // ---------------- next write clears the sticky error ----------------
        host_write(8'h3C);
        check("clr_error", tx_error, 1'b0);
        check("clr_busy",  kbtsr,    1'b0);
        finish_frame(8'h3C, 50, 1'b1, "after_err");

        // ---------------- write while busy is ignored ----------------
        a0 = ack_count;
        host_write(8'hF4);
        fork
            finish_frame(8'hF4, 50, 1'b1, "busy");
            begin
                int n = 0;
                while (dev_edge < 4 && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
                check("busy_edge4_reached", dev_edge >= 4, 1'b1);
                cycles(5);
                host_write(8'h55);
                check("busy_kbtsr", kbtsr, 1'b0);
            end
        join
        check("busy_total_acks", ack_count - a0, 1);

        // ---------------- watchdog timeout ----------------
        a0 = ack_count;
        host_write(8'h12);
        wait_clk_level(1'b0, 100, "to_inhibit_seen");
        wait_clk_level(1'b1, 1000, "to_inhibit_end");
        cycles(TIMEOUT_CYCLES - 20);
        check("to_before_busy",  kbtsr,    1'b0);
        check("to_before_error", tx_error, 1'b0);
        check("to_before_start", ps2_data, 1'b0);
        cycles(40);
        check("to_error",    tx_error, 1'b1);
        check("to_kbtsr",    kbtsr,    1'b1);
        check("to_clk_pin",  ps2_clk,  1'b1);
        check("to_data_pin", ps2_data, 1'b1);
        check("to_acks",     ack_count - a0, 0);

        // ---------------- reset at edge 5 ----------------
        a0 = ack_count;
        host_write(8'hE5);                       // bit 4 = 0, so DATA is held low
        wait_clk_level(1'b0, 100, "mid_inhibit_seen");
        wait_clk_level(1'b1, 1000, "mid_inhibit_end");
        cycles(50);
        for (int e = 1; e <= 4; e++) begin
            dev_clk_low = 1'b1;
            cycles(50);
            dev_clk_low = 1'b0;
            cycles(50);
        end
        dev_clk_low = 1'b1;
        cycles(10);
        check("mid_bit4_driven", ps2_data, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("mid_data_released", ps2_data, 1'b1);
        dev_clk_low = 1'b0;
        #1;
        check("mid_clk_released", ps2_clk, 1'b1);
        @(negedge clk);
        check("mid_kbtsr", kbtsr,    1'b1);
        check("mid_error", tx_error, 1'b0);
        cycles(3);
        rst = 1'b0;
        cycles(300);
        check("mid_acks",    ack_count - a0, 0);
        check("mid_idle",    kbtsr,    1'b1);
        check("mid_error2",  tx_error, 1'b0);
        run_frame(8'h5A, 50, 1'b1, "recover");

        // ---------------- randomized frames ----------------
        for (int i = 0; i < 6; i++) begin
            logic [7:0] d;
            int         half;
            bit         ack;
            d    = 8'($urandom);
            half = $urandom_range(15, 40);
            ack  = ($urandom_range(0, 3) != 0);
            run_frame(d, half, ack, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_tx.md
PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 200: SYSTEM_CLOCK cycles the PS/2 clock is held low before the start bit (100 us at 2 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 30000: the maximum number of cycles allowed between consecutive device clock falling edges (15 ms at 2 MHz).
REQ-003 SYSTEM_CLOCK  in  1  single clock, rising-edge; all state is in this domain.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 write_kbtdr  in  1  one-cycle request to transmit kbtdr_in.
REQ-006 kbtdr_in  in  8  command byte to send (for example 0xED for set-LEDs).
REQ-007 kbtsr  out  1  1 = idle and a write is accepted; 0 = busy.
REQ-008 tx_ack  out  1  one-cycle pulse when the device acknowledges the frame.
REQ-009 tx_error  out  1  sticky flag for a failed frame (timeout or missing ack).
REQ-010 PS2KEYBOARD_CLK  inout  1  open-drain: driven 1'b0 or 1'bz, never 1'b1.
REQ-011 PS2KEYBOARD_DATA  inout  1  open-drain: driven 1'b0 or 1'bz, never 1'b1.

Function
REQ-012 Both pin inputs SHALL pass through a 2-flop synchronizer; edge detection uses the synchronized clock (falling edge = previous 1, current 0).
REQ-013 FSM states SHALL be IDLE, INHIBIT, SEND, ACK and WAIT_IDLE; kbtsr = 1 only in IDLE.
REQ-014 IDLE: write_kbtdr=1 latches kbtdr_in, computes odd parity (~^data), clears tx_error and goes to INHIBIT on the next edge.
REQ-015 INHIBIT: the block drives CLK low and releases DATA for exactly INHIBIT_CYCLES cycles.
REQ-016 At the end of INHIBIT, the block drives DATA low (start bit) and releases CLK in the same cycle, then enters SEND with bit_cnt=0 and the watchdog cleared.
REQ-017 SEND, on each synchronized falling edge, updates DATA in the same cycle the edge is detected:
  - edges 1-8: data bit 0-7, LSB first (0 = drive low, 1 = release);
  - edge 9: parity bit;
  - edge 10: release DATA (stop bit), then go to ACK.
REQ-018 ACK: at the 11th falling edge, synchronized DATA=0 pulses tx_ack for one cycle; DATA=1 sets tx_error. Either way, go to WAIT_IDLE.
REQ-019 WAIT_IDLE: the block returns to IDLE once synchronized CLK and DATA have both been 1 for one cycle.
REQ-020 Watchdog in SEND, ACK and WAIT_IDLE:
  - counts cycles and clears on each falling edge;
  - on reaching TIMEOUT_CYCLES: release both lines, set tx_error, go to IDLE, no tx_ack.
REQ-021 write_kbtdr while kbtsr=0 SHALL be ignored: no latch, no state change, no effect on tx_error.
REQ-022 Simultaneous write_kbtdr and a pending error in IDLE: the write wins, and tx_error clears next cycle.
REQ-023 Glitch-free pins: outside INHIBIT and SEND both lines are released; CLK is driven only in INHIBIT.
REQ-024 Counters SHALL be wide enough for max(INHIBIT_CYCLES, TIMEOUT_CYCLES) without wrap-around.
REQ-025 Receive-side traffic (device-to-host frames on the shared pins) while in IDLE SHALL NOT change any state.

Reset
REQ-026 On reset, the FSM enters IDLE asynchronously and both pins are released (Z) immediately, including mid-frame.
REQ-027 Reset values: kbtsr=1, tx_ack=0, tx_error=0, bit_cnt=0, watchdog=0, latched data=0x00.
REQ-028 After reset deasserts, the first write_kbtdr is accepted normally.

Verification
REQ-029 Nominal frame:
  - stimulus: write 0xED; device model clocks at 10 kHz and acks;
  - CLK low for 200 cycles, then start bit 0;
  - device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - tx_ack pulses once, tx_error=0, kbtsr returns to 1.
REQ-030 Parity checks:
  - write 0x00: parity 1;
  - write 0xFF: parity 1;
  - write 0x01: parity 0;
  - all are sampled correctly by the device model.
REQ-031 Missing ack: the device leaves DATA high at edge 11 -> tx_error=1, no tx_ack, kbtsr=1 after the lines go idle; the next write clears tx_error.
REQ-032 Timeout: the device never clocks after INHIBIT -> after TIMEOUT_CYCLES cycles tx_error=1, both pins Z, kbtsr=1.
REQ-033 Busy write: write 0xF4, then write 0x55 at edge 4 -> the device receives only 0xF4 and exactly one tx_ack occurs.
REQ-034 Reset mid-frame: assert reset at edge 5 -> pins Z in the same cycle, kbtsr=1, tx_error=0, tx_ack never pulses.
